sevenseg_scan_driver: RTL and testbench

//  Consumes BCD digit pairs from the binary-to-BCD converter and drives a 4-digit

---
 rtl/sevenseg_scan_driver.sv | 112 +++++++++++
 tb/tb_sevenseg_scan_driver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// Captures BCD digit pairs on done_tick and time-multiplexes them onto a 4-digit common-anode display.
// Outputs are registered one cycle behind scan index/digits. There is no backpressure, so every done_tick is captured.
module sevenseg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done_tick,
    input  logic       slot,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic       colon_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [3:0]       digit_q [4];
    logic [3:0]       digit_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       cur_digit;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes render as a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_d[i] = digit_q[i];
        end
        if (done_tick) begin
            if (slot) begin
                digit_d[2] = bcd1;
                digit_d[3] = bcd2;
            end else begin
                digit_d[0] = bcd1;
                digit_d[1] = bcd2;
            end
        end

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        // Output stage sees the pre-edge index and digits, giving a fixed one-cycle lag.
        cur_digit = digit_q[idx_q];
        an_d      = ~(4'b0001 << idx_q);
        if (BLANK_LEAD && (idx_q == 2'd3) && (cur_digit == 4'd0)) begin
            seg_d = SEG_OFF;
        end else begin
            seg_d = decode(cur_digit);
        end
        dp_d = ~(colon_en && (idx_q == 2'd2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'd0;
            end
            cnt_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
            end
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: directed scenarios plus random traffic against a cycle-count reference model.
module tb_sevenseg_scan_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset, done_tick, slot, colon_en;
    logic [3:0] bcd1, bcd2;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b1)) dut_blank (
        .clk(clk), .reset(reset), .done_tick(done_tick), .slot(slot),
        .bcd1(bcd1), .bcd2(bcd2), .colon_en(colon_en),
        .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    sevenseg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b0)) dut_noblank (
        .clk(clk), .reset(reset), .done_tick(done_tick), .slot(slot),
        .bcd1(bcd1), .bcd2(bcd2), .colon_en(colon_en),
        .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    logic [6:0] seg_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // Model: digits held as captured; the lit digit follows from edges elapsed since reset.
    logic [3:0]  m_dig [4];
    int unsigned m_edges;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic step();
        int         idx;
        logic [3:0] v;
        logic [3:0] e_an;
        logic [6:0] e_seg_a, e_seg_b;
        logic       e_dp;
        @(posedge clk);
        if (reset) begin
            e_an    = 4'b1111;
            e_seg_a = 7'b1111111;
            e_seg_b = 7'b1111111;
            e_dp    = 1'b1;
            m_edges = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        end else begin
            idx     = int'((m_edges / DIV) % 4);
            v       = m_dig[idx];
            e_an    = 4'b1111;
            e_an[idx] = 1'b0;
            e_seg_b = seg_lut[v];
            e_seg_a = (idx == 3 && v == 4'd0) ? 7'b1111111 : seg_lut[v];
            e_dp    = !(colon_en && idx == 2);
            m_edges++;
            if (done_tick) begin
                if (slot) begin
                    m_dig[2] = bcd1;
                    m_dig[3] = bcd2;
                end else begin
                    m_dig[0] = bcd1;
                    m_dig[1] = bcd2;
                end
            end
        end
        #1;
        chk("an_blank",    32'(an_a),  32'(e_an));
        chk("seg_blank",   32'(seg_a), 32'(e_seg_a));
        chk("dp_blank",    32'(dp_a),  32'(e_dp));
        chk("an_noblank",  32'(an_b),  32'(e_an));
        chk("seg_noblank", 32'(seg_b), 32'(e_seg_b));
        chk("dp_noblank",  32'(dp_b),  32'(e_dp));
    endtask

    task automatic drive(input logic r, input logic dt, input logic sl,
                         input logic [3:0] b1, input logic [3:0] b2, input logic ce);
        reset = r; done_tick = dt; slot = sl; bcd1 = b1; bcd2 = b2; colon_en = ce;
        step();
    endtask

    task automatic idle(input int n, input logic ce);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, ce);
    endtask

    initial begin
        reset = 1'b1; done_tick = 1'b0; slot = 1'b0; colon_en = 1'b0;
        bcd1 = 4'd0; bcd2 = 4'd0;
        m_edges = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;

        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("reset_an_const", 32'(an_a), 32'h0000000F);
        idle(20, 1'b0);

        drive(1'b0, 1'b1, 1'b0, 4'd9, 4'd5, 1'b0);
        idle(16, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
        idle(16, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'hB, 4'd3, 1'b0);
        idle(16, 1'b1);

        // Back-to-back captures into both slots.
        drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd4, 1'b0);
        idle(16, 1'b0);

        idle(5, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b1);
        chk("midscan_reset_seg", 32'(seg_a), 32'h0000007F);
        idle(18, 1'b0);

        // Capture on the wrap edge while the destination digit is lit.
        for (int i = 0; i < 40; i++) begin
            if ((m_edges % DIV) == DIV - 1 && ((m_edges / DIV) % 4) == 0) break;
            idle(1, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd6, 4'd8, 1'b0);
        idle(18, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
        idle(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
